// File: rtl/mac_pkg.sv
// mac_pkg: state encoding, pipeline constants and the accumulator overflow bound for the MAC sequencer
package mac_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, CAPTURE, HOLD} mac_seq_state_t;

    localparam int MAC_RD_LAT     = 1;
    localparam int MAC_PIPE_DEPTH = 2;

    // Longest dot product whose worst-case sum still fits the accumulator
    function automatic bit mac_len_ok(input int max_len, input int in_w, input int out_w);
        return max_len <= (1 << (out_w - 2 * in_w));
    endfunction

endpackage

// File: rtl/mac_en_pipe.sv
// mac_en_pipe: valid delay line turning the read strobe into MAC stage enables
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous flush of every stage
//   din        : valid entering stage 0
//   q          : q[k] is din delayed k+1 cycles
module mac_en_pipe #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             din,
    output logic [DEPTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else
            q <= {q[DEPTH-2:0], din};

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences operand reads and MAC enables for one length-N dot product
//   clk, rst_n                    : clock, async active-low reset
//   start, len, img_base, w_base  : job request, sampled when accepted in IDLE
//   abort                         : cancel the running job and scrub the MAC
//   busy                          : job in progress
//   rd_en, img_addr, w_addr       : operand memory reads (data valid one cycle later)
//   rst_mem, mul_mem_en, ac_mem_en: MAC clear and stage enables
//   mac_out                       : MAC accumulator
//   result_data/valid/ready       : captured dot product handshake
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 22,
    parameter int MAX_LEN    = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [ADDR_WIDTH-1:0] img_base,
    input  logic [ADDR_WIDTH-1:0] w_base,
    input  logic                  abort,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] img_addr,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  rst_mem,
    output logic                  mul_mem_en,
    output logic                  ac_mem_en,
    input  logic [OUT_WIDTH-1:0]  mac_out,
    output logic [OUT_WIDTH-1:0]  result_data,
    output logic                  result_valid,
    input  logic                  result_ready
);

    if (!mac_len_ok(MAX_LEN, IN_WIDTH, OUT_WIDTH)) begin : g_len_chk
        $error("mac_seq_ctrl: MAX_LEN exceeds the accumulator no-overflow bound");
    end

    localparam logic [LEN_WIDTH-1:0] ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LMAX = LEN_WIDTH'(MAX_LEN);

    mac_seq_state_t              state, nxt;
    logic [LEN_WIDTH-1:0]        len_r, i;
    logic [ADDR_WIDTH-1:0]       img_b, w_b;
    logic                        scrub, kill;
    logic [MAC_PIPE_DEPTH-1:0]   pipe;

    assign kill = abort && state != IDLE;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? CLEAR : IDLE;
            CLEAR:   nxt = len_r != '0 ? RUN : DRAIN;
            RUN:     nxt = i + ONE == len_r ? DRAIN : RUN;
            DRAIN:   nxt = i == ONE ? CAPTURE : DRAIN;
            CAPTURE: nxt = HOLD;
            HOLD:    nxt = result_ready ? IDLE : HOLD;
            default: nxt = IDLE;
        endcase
        if (kill)
            nxt = IDLE;
    end

    // i counts cycles within RUN (read index) and within DRAIN; it restarts on every state change
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= IDLE;
            len_r       <= '0;
            img_b       <= '0;
            w_b         <= '0;
            i           <= '0;
            scrub       <= 1'b0;
            result_data <= '0;
        end else begin
            state <= nxt;
            scrub <= kill;
            i     <= nxt == state && (state == RUN || state == DRAIN) ? i + ONE : '0;
            if (state == IDLE && start) begin
                len_r <= len > LMAX ? LMAX : len;
                img_b <= img_base;
                w_b   <= w_base;
            end
            if (state == CAPTURE && !kill)
                result_data <= mac_out;
        end

    mac_en_pipe #(.DEPTH(MAC_PIPE_DEPTH)) u_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (kill),
        .din  (rd_en),
        .q    (pipe)
    );

    assign busy         = state != IDLE;
    assign rd_en        = state == RUN;
    assign img_addr     = rd_en ? img_b + ADDR_WIDTH'(i) : '0;
    assign w_addr       = rd_en ? w_b + ADDR_WIDTH'(i) : '0;
    // scrub gives the one-cycle MAC clear that follows an abort
    assign rst_mem      = state == CLEAR || scrub;
    assign mul_mem_en   = pipe[MAC_RD_LAT-1] && !rst_mem;
    assign ac_mem_en    = pipe[MAC_PIPE_DEPTH-1] && !rst_mem;
    assign result_valid = state == HOLD;

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for one MAC unit (8x8 multiply, registered product, 22-bit accumulator) that computes a length-N dot product.
- Issues image/weight memory reads and drives the MAC's rst_mem, mul_mem_en and ac_mem_en with correct pipeline alignment.
- Captures the final accumulator value and presents it on a valid/ready result interface.
- Sits between the layer controller (start/len/base addresses) and the MAC plus its two operand memories.

Parameters:
- IN_WIDTH, 8: operand width at the MAC.
- OUT_WIDTH, 22: MAC accumulator width; also the result width.
- MAX_LEN, 64: maximum dot-product length. Elaboration error if MAX_LEN > 2**(OUT_WIDTH-2*IN_WIDTH), the no-overflow bound.
- ADDR_WIDTH, 10: operand memory address width.
- LEN_WIDTH, $clog2(MAX_LEN+1): width of len.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: job request; accepted only in IDLE.
- len, input, LEN_WIDTH: number of products; sampled on start accept.
- img_base, input, ADDR_WIDTH: first image address; sampled on start accept.
- w_base, input, ADDR_WIDTH: first weight address; sampled on start accept.
- abort, input, 1: cancel the current job.
- busy, output, 1: high when state != IDLE.
- rd_en, output, 1: read strobe to both operand memories. Read data is valid exactly 1 cycle later.
- img_addr, output, ADDR_WIDTH: image read address.
- w_addr, output, ADDR_WIDTH: weight read address.
- rst_mem, output, 1: to MAC; clears the product and accumulator registers.
- mul_mem_en, output, 1: to MAC product register enable.
- ac_mem_en, output, 1: to MAC accumulator enable.
- mac_out, input, OUT_WIDTH: from MAC accumulator.
- result_data, output, OUT_WIDTH: captured dot product.
- result_valid, output, 1: result available.
- result_ready, input, 1: consumer accepts the result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, including addresses, result_data and the pipeline valid bits.
- States: IDLE, CLEAR, RUN, DRAIN, CAPTURE, HOLD.
- IDLE, start=1: register len and both bases; cycle-0 edge moves to CLEAR.
- CLEAR (1 cycle): rst_mem=1.
  - Next state is RUN if len>0, else DRAIN.
  - Read counter i=0.
- RUN (len cycles):
  - rd_en=1, img_addr=img_base+i, w_addr=w_base+i. Address addition wraps mod 2**ADDR_WIDTH.
  - i increments each cycle. After the i=len-1 cycle, go to DRAIN.
- Pipeline alignment: two-stage valid shift register fed by rd_en.
  - mul_mem_en = rd_en delayed 1 cycle.
  - ac_mem_en = rd_en delayed 2 cycles.
  - Both are forced low whenever rst_mem=1.
- DRAIN (2 cycles): no reads. The pipeline empties; the last ac_mem_en occurs in the second DRAIN cycle.
- CAPTURE (1 cycle): result_data <= mac_out.
- HOLD: result_valid=1 and result_data stable until result_ready=1. On that cycle's edge, go to IDLE and result_valid falls.
- Timing for start accepted at cycle 0:
  - rst_mem in cycle 1.
  - rd_en in cycles 2..len+1.
  - mul_mem_en in cycles 3..len+2.
  - ac_mem_en in cycles 4..len+3.
  - result_valid first high in cycle len+5.
  - A len=0 job gives result_valid at cycle 5 with result_data=0.
- start while busy: ignored; no queuing.
- start in the same cycle as a HOLD handshake: ignored, since the state is not yet IDLE.
- len > MAX_LEN: clamped to MAX_LEN.
- abort=1 in any non-IDLE state:
  - Next edge goes to IDLE.
  - rd_en, mul_mem_en, ac_mem_en and result_valid are low from the next cycle; pipeline valid bits are cleared.
  - rst_mem=1 for that one following cycle, scrubbing the MAC.
  - result_data is retained, not updated.
  - Abort takes priority over every other transition. Abort in IDLE has no effect.
- Reset mid-job: immediate return to IDLE. The MAC contents are don't-care; the next job's CLEAR scrubs them.
- Arithmetic: the controller does no datapath math. Counter i has LEN_WIDTH bits and never wraps because of the clamp.

Decomposition:
- Package mac_pkg:
  - typedef enum logic [2:0] mac_seq_state_t {IDLE, CLEAR, RUN, DRAIN, CAPTURE, HOLD}.
  - localparams MAC_RD_LAT=1 and MAC_PIPE_DEPTH=2.
  - The overflow-bound function used by the parameter check.
- Sub-module mac_en_pipe: parameterized valid delay line (depth MAC_PIPE_DEPTH, synchronous clear) producing mul_mem_en/ac_mem_en from rd_en.
- The rest is a single FSM-plus-counter module.

Test Plan:
- Basic job: len=4, img_base=10, w_base=200, MAC plus memory model with img[k]=k+1 and w[k]=2. Required: rd_en in cycles 2..5; addresses 10..13 and 200..203; result_valid at cycle 9; result_data=20.
- Max-length overflow bound: len=64, all operands 255, result_ready tied 1. Required: result_data=4161600; valid for exactly 1 cycle; then busy=0.
- Back-pressure and ignored start: hold result_ready=0 for 10 cycles with start pulsed during HOLD. Required: result_valid and result_data stable; no new rd_en; IDLE after the ready handshake.
- Abort mid-RUN: len=8, abort in cycle 5. Required: cycle 6 has rst_mem=1 and rd_en=mul_mem_en=ac_mem_en=0; busy=0; result_valid never asserts.
- Edge lengths: len=0 gives result 0 at cycle 5. len=100 with MAX_LEN=64 gives exactly 64 rd_en cycles. img_base=1020 gives img_addr wrapping 1023→0.
- Async reset: assert rst_n=0 mid-DRAIN between clock edges. Required: all outputs 0 immediately; a new start after release runs a correct len=3 job.
